// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave front-end for the single-port RAM.
// Deserialises 10-bit MOSI frames into rx_data/rx_valid, tracks whether a
// read address has been issued, and serialises RAM read data out on MISO.
// Optional build macro: SPI_FRAME_CHECK_EN (suppress frames whose cmd bits
// disagree with the state the FSM chose).
module spi_slave_ctrl #(
    parameter logic [2:0] IDLE_ENC = 3'b000,
    parameter int         FRAME_W  = 10,
    parameter int         DATA_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);
    localparam int TXC_W = $clog2(DATA_W + 1);

    // XOR offsets keep every encoding distinct whatever IDLE_ENC is
    typedef enum logic [2:0] {
        IDLE      = IDLE_ENC,
        CHK_CMD   = IDLE_ENC ^ 3'd1,
        WRITE     = IDLE_ENC ^ 3'd2,
        READ_ADD  = IDLE_ENC ^ 3'd3,
        READ_DATA = IDLE_ENC ^ 3'd4
    } state_t;

    state_t             state, nxt;
    logic [3:0]         bit_cnt;     // frame bits sampled so far
    logic [FRAME_W-2:0] rx_sh;       // bits 9..1 once the frame is nearly done
    logic [FRAME_W-1:0] frame;       // complete frame as seen at the last bit
    logic               rd_addr_ok;  // a read address is pending its data phase
    logic               rd_wait;     // read-data frame issued, waiting on RAM
    logic               tx_busy;
    logic [TXC_W-1:0]   tx_cnt;      // read-data bits already driven on MISO
    logic [DATA_W-1:0]  tx_sh;
    logic               shifting, last_bit, frame_ok, fire;

    assign frame    = {rx_sh, MOSI};
    assign shifting = (state == WRITE || state == READ_ADD || state == READ_DATA) &&
                      (bit_cnt != 4'(FRAME_W));
    assign last_bit = shifting && (bit_cnt == 4'(FRAME_W - 1));
    assign fire     = last_bit && !SS_n && frame_ok;

    // Decide whether a completed frame is allowed to reach the RAM
    always_comb begin
        frame_ok = 1'b1;
`ifdef SPI_FRAME_CHECK_EN
        case (state)
            WRITE:     frame_ok = ~frame[FRAME_W-1];
            READ_ADD:  frame_ok = (frame[FRAME_W-1 -: 2] == 2'b10);
            READ_DATA: frame_ok = (frame[FRAME_W-1 -: 2] == 2'b11);
            default:   frame_ok = 1'b0;
        endcase
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next state: SS_n high always wins; command bit picks the frame type
    always_comb begin
        nxt = state;
        if (state != IDLE && SS_n) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (!SS_n) nxt = CHK_CMD;
                CHK_CMD: nxt = MOSI ? (rd_addr_ok ? READ_DATA : READ_ADD) : WRITE;
                default: nxt = state;
            endcase
        end
    end

    // Frame shift-in, rx strobe, read-address flag and MISO serialiser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            rx_sh      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rd_addr_ok <= 1'b0;
            rd_wait    <= 1'b0;
            tx_busy    <= 1'b0;
            tx_cnt     <= '0;
            tx_sh      <= '0;
            MISO       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                bit_cnt <= '0;
                MISO    <= 1'b0;
                rd_wait <= 1'b0;
                tx_busy <= 1'b0;
                tx_cnt  <= '0;
                // last data bit was on the pins for its full cycle
                if (tx_busy && tx_cnt == TXC_W'(DATA_W)) rd_addr_ok <= 1'b0;
            end else begin
                if (state == CHK_CMD || shifting) begin
                    rx_sh   <= {rx_sh[FRAME_W-3:0], MOSI};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (fire) begin
                    rx_data  <= frame;
                    rx_valid <= 1'b1;
                    if (state == READ_ADD)  rd_addr_ok <= 1'b1;
                    if (state == READ_DATA) rd_wait    <= 1'b1;
                end
                if (rd_wait && tx_valid) begin
                    MISO    <= tx_data[DATA_W-1];
                    tx_sh   <= tx_data << 1;
                    tx_cnt  <= TXC_W'(1);
                    tx_busy <= 1'b1;
                    rd_wait <= 1'b0;
                end else if (tx_busy && tx_cnt != TXC_W'(DATA_W)) begin
                    MISO   <= tx_sh[DATA_W-1];
                    tx_sh  <= tx_sh << 1;
                    tx_cnt <= tx_cnt + 1'b1;
                end else if (tx_busy) begin
                    MISO       <= 1'b0;
                    rd_addr_ok <= 1'b0;
                    tx_busy    <= 1'b0;
                    tx_cnt     <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: a table of full 20-edge SS_n-low
// transactions plus hand-written abort and reset sequences.
module tb_spi_slave_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    spi_slave_ctrl dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] frame;
        logic [7:0] txb;
        int         exp_pulses;
        logic [9:0] exp_data;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Edges 0..n_low-1 with SS_n low, then one edge with SS_n high.
    // tx_valid is offered at edge 12 whatever the frame type.
    task automatic run_seq(input logic [9:0] f, input logic [7:0] txb, input int n_low,
                           output int pulses, output int pedge, output logic [9:0] data,
                           output logic [7:0] mb, output logic mafter);
        pulses = 0; pedge = -1; data = '0; mb = '0;
        SS_n = 1'b0;
        for (int e = 0; e < n_low; e++) begin
            MOSI     = (e >= 1 && e <= 10) ? f[10-e] : 1'b1;
            tx_valid = (e == 12);
            tx_data  = txb;
            @(posedge clk); #1;
            if (rx_valid === 1'b1) begin pulses++; pedge = e; data = rx_data; end
            if (e >= 12 && e <= 19) mb[19-e] = MISO;
        end
        SS_n = 1'b1; tx_valid = 1'b0; MOSI = 1'b0;
        @(posedge clk); #1;
        if (rx_valid === 1'b1) pulses++;
        mafter = MISO;
        @(posedge clk); #1;
    endtask

    int         p, pe;
    logic [9:0] d;
    logic [7:0] mb;
    logic       ma;

    initial begin
        tbl[0] = '{10'b00_0000_0101, 8'hAA, 1, 10'h005, 8'h00};
        tbl[1] = '{10'b01_1010_1010, 8'h55, 1, 10'h1AA, 8'h00};
        tbl[2] = '{10'b10_0000_0101, 8'h33, 1, 10'h205, 8'h00};
        tbl[3] = '{10'b11_1111_0000, 8'hAA, 1, 10'h3F0, 8'hAA};
`ifdef SPI_FRAME_CHECK_EN
        tbl[4] = '{10'b11_0000_0001, 8'h5A, 0, 10'h000, 8'h00};
        tbl[5] = '{10'b11_0000_0000, 8'hC3, 0, 10'h000, 8'h00};
`else
        tbl[4] = '{10'b11_0000_0001, 8'h5A, 1, 10'h301, 8'h00};
        tbl[5] = '{10'b11_0000_0000, 8'hC3, 1, 10'h300, 8'hC3};
`endif
        tbl[6] = '{10'b10_1111_1111, 8'h11, 1, 10'h2FF, 8'h00};
        tbl[7] = '{10'b11_0101_0101, 8'h96, 1, 10'h355, 8'h96};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_miso", 32'(MISO), 0);
        chk("reset_rx_valid", 32'(rx_valid), 0);
        chk("reset_rx_data", 32'(rx_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_seq(tbl[i].frame, tbl[i].txb, 20, p, pe, d, mb, ma);
            chk($sformatf("v%0d_pulses", i), 32'(p), 32'(tbl[i].exp_pulses));
            if (tbl[i].exp_pulses != 0) begin
                chk($sformatf("v%0d_pulse_edge", i), 32'(pe), 10);
                chk($sformatf("v%0d_rx_data", i), 32'(d), 32'(tbl[i].exp_data));
            end
            chk($sformatf("v%0d_miso_byte", i), 32'(mb), 32'(tbl[i].exp_miso));
            chk($sformatf("v%0d_miso_after", i), 32'(ma), 0);
        end

        // abort a write after 6 bits, then a full write must decode
        run_seq(10'b00_1111_1111, 8'h00, 7, p, pe, d, mb, ma);
        chk("abort_wr_pulses", 32'(p), 0);
        chk("abort_wr_rx_data_held", 32'(rx_data), 32'(10'h355));
        run_seq(10'b00_1100_0011, 8'h00, 20, p, pe, d, mb, ma);
        chk("after_abort_pulses", 32'(p), 1);
        chk("after_abort_data", 32'(d), 32'(10'h0C3));

        // abort during MISO shift after 3 bits; address flag must survive
        run_seq(10'b10_0000_0001, 8'h00, 20, p, pe, d, mb, ma);
        chk("rdadd_data", 32'(d), 32'(10'h201));
        run_seq(10'b11_0000_0001, 8'hAA, 15, p, pe, d, mb, ma);
        chk("abort_rd_pulses", 32'(p), 1);
        chk("abort_rd_bits", 32'(mb[7:5]), 32'(3'b101));
        chk("abort_rd_miso_after", 32'(ma), 0);
        run_seq(10'b11_0000_0010, 8'h3C, 20, p, pe, d, mb, ma);
        chk("resume_rd_miso", 32'(mb), 32'(8'h3C));
        chk("resume_rd_data", 32'(d), 32'(10'h302));

        // reset mid READ_DATA, right after MISO carries bit7
        run_seq(10'b10_0000_1000, 8'h00, 20, p, pe, d, mb, ma);
        SS_n = 1'b0;
        for (int e = 0; e <= 12; e++) begin
            MOSI     = (e >= 1 && e <= 10) ? tbl[3].frame[10-e] : 1'b0;
            tx_valid = (e == 12);
            tx_data  = 8'hAA;
            @(posedge clk); #1;
        end
        chk("pre_reset_miso", 32'(MISO), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_miso", 32'(MISO), 0);
        chk("async_rst_rx_valid", 32'(rx_valid), 0);
        chk("async_rst_rx_data", 32'(rx_data), 0);
        SS_n = 1'b1; tx_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_seq(10'b11_0000_0111, 8'hFF, 20, p, pe, d, mb, ma);
        chk("post_rst_is_rdadd", 32'(mb), 0);
`ifdef SPI_FRAME_CHECK_EN
        chk("post_rst_pulses", 32'(p), 0);
`else
        chk("post_rst_pulses", 32'(p), 1);
        chk("post_rst_data", 32'(d), 32'(10'h307));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
